// File: rtl/axil_ctrl_bridge_if.sv
// ----------------------------------------------------------------------------
// axil_ctrl_bridge_if
// AXI4-Lite bundle between an SoC master and the Garnet control bridge.
//
// Signals (names follow the slave-side view, prefixed s_):
//   AW : s_awaddr, s_awvalid, s_awready
//   W  : s_wdata, s_wstrb, s_wvalid, s_wready
//   B  : s_bresp, s_bvalid, s_bready
//   AR : s_araddr, s_arvalid, s_arready
//   R  : s_rdata, s_rresp, s_rvalid, s_rready
// Modports:
//   slave  - the bridge (receives AW/W/AR, drives B/R)
//   master - the requester (drives AW/W/AR, receives B/R)
// ----------------------------------------------------------------------------
interface axil_ctrl_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;

  logic [DATA_WIDTH-1:0] s_wdata;
  logic [STRB_WIDTH-1:0] s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;

  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;

  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;

  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;

  modport slave (
    input  s_awaddr, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wvalid,
    output s_wready,
    output s_bresp, s_bvalid,
    input  s_bready,
    input  s_araddr, s_arvalid,
    output s_arready,
    output s_rdata, s_rresp, s_rvalid,
    input  s_rready
  );

  modport master (
    output s_awaddr, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wvalid,
    input  s_wready,
    input  s_bresp, s_bvalid,
    output s_bready,
    output s_araddr, s_arvalid,
    input  s_arready,
    input  s_rdata, s_rresp, s_rvalid,
    output s_rready
  );

endinterface

// File: rtl/axil_ctrl_bridge.sv
// ----------------------------------------------------------------------------
// axil_ctrl_bridge
// AXI4-Lite slave in front of the Garnet global controller. AW, W and AR are
// each captured into a one-entry holding register, reads and writes are
// arbitrated round-robin, and a single register-bus request is issued to the
// core at a time. Proper B/R responses are returned, with SLVERR for a
// misaligned address, a core error, or a core that never answers.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   s_axil         AXI4-Lite slave bundle (axil_ctrl_bridge_if.slave)
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb
//                  register-bus request to the core (held until accepted)
//   rsp_valid/rsp_rdata/rsp_err
//                  core completion pulse, read data, error flag
//   busy           high whenever a transaction is in progress
//
// DATA_WIDTH is expected to be 32 or 64. TIMEOUT = 0 waits forever.
// ----------------------------------------------------------------------------
module axil_ctrl_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  axil_ctrl_bridge_if.slave     s_axil,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic [STRB_WIDTH-1:0] req_wstrb,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  rsp_err,
  output logic                  busy
);

  localparam int LSB_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;
  // The wait counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [STRB_WIDTH-1:0] STRB_ZERO = {STRB_WIDTH{1'b0}};
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One-hot so each Moore output is a single flop bit.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_REQ   = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_BRESP = 5'b01000,
    ST_RRESP = 5'b10000
  } state_e;

  // An address is misaligned when any byte-offset bit inside a data word is set.
  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
    return |addr[LSB_W-1:0];
  endfunction

  state_e                state_r;
  state_e                state_s;

  logic                  aw_full_r;
  logic                  awready_r;
  logic [ADDR_WIDTH-1:0] aw_addr_r;
  logic                  w_full_r;
  logic                  wready_r;
  logic [DATA_WIDTH-1:0] w_data_r;
  logic [STRB_WIDTH-1:0] w_strb_r;
  logic                  ar_full_r;
  logic                  arready_r;
  logic [ADDR_WIDTH-1:0] ar_addr_r;

  logic                  ptr_write_r;
  logic                  cur_write_r;
  logic [ADDR_WIDTH-1:0] req_addr_r;
  logic [DATA_WIDTH-1:0] req_wdata_r;
  logic [STRB_WIDTH-1:0] req_wstrb_r;
  logic [1:0]            resp_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [CNT_W-1:0]      cnt_r;

  logic                  aw_load_s;
  logic                  w_load_s;
  logic                  ar_load_s;
  logic                  consume_b_s;
  logic                  consume_r_s;
  logic                  wr_pend_s;
  logic                  rd_pend_s;
  logic                  grant_wr_s;
  logic                  grant_rd_s;
  logic [ADDR_WIDTH-1:0] grant_addr_s;
  logic                  grant_misal_s;
  logic                  timeout_s;

  // Handshake strobes, pending flags and the round-robin grant decision
  always_comb begin
    aw_load_s   = s_axil.s_awvalid & awready_r;
    w_load_s    = s_axil.s_wvalid  & wready_r;
    ar_load_s   = s_axil.s_arvalid & arready_r;
    consume_b_s = (state_r == ST_BRESP) & s_axil.s_bready;
    consume_r_s = (state_r == ST_RRESP) & s_axil.s_rready;
    wr_pend_s   = aw_full_r & w_full_r;
    rd_pend_s   = ar_full_r;
    // The pointer only matters when both request types are waiting.
    grant_wr_s  = wr_pend_s & (~rd_pend_s | ptr_write_r);
    grant_rd_s  = rd_pend_s & ~grant_wr_s;
    if (grant_wr_s) begin
      grant_addr_s = aw_addr_r;
    end else begin
      grant_addr_s = ar_addr_r;
    end
    grant_misal_s = is_misaligned(grant_addr_s);
    timeout_s     = TO_EN & (cnt_r == CNT_LAST);
  end

  // AW holding register; frees only once the write response is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_full_r <= 1'b0;
      awready_r <= 1'b0;
      aw_addr_r <= ADDR_ZERO;
    end else if (consume_b_s) begin
      aw_full_r <= 1'b0;
      awready_r <= 1'b1;
    end else if (aw_load_s) begin
      aw_full_r <= 1'b1;
      awready_r <= 1'b0;
      aw_addr_r <= s_axil.s_awaddr;
    end else begin
      awready_r <= ~aw_full_r;
    end
  end

  // W holding register; frees together with AW on the write response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_full_r <= 1'b0;
      wready_r <= 1'b0;
      w_data_r <= DATA_ZERO;
      w_strb_r <= STRB_ZERO;
    end else if (consume_b_s) begin
      w_full_r <= 1'b0;
      wready_r <= 1'b1;
    end else if (w_load_s) begin
      w_full_r <= 1'b1;
      wready_r <= 1'b0;
      w_data_r <= s_axil.s_wdata;
      w_strb_r <= s_axil.s_wstrb;
    end else begin
      wready_r <= ~w_full_r;
    end
  end

  // AR holding register; frees once the read response is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ar_full_r <= 1'b0;
      arready_r <= 1'b0;
      ar_addr_r <= ADDR_ZERO;
    end else if (consume_r_s) begin
      ar_full_r <= 1'b0;
      arready_r <= 1'b1;
    end else if (ar_load_s) begin
      ar_full_r <= 1'b1;
      arready_r <= 1'b0;
      ar_addr_r <= s_axil.s_araddr;
    end else begin
      arready_r <= ~ar_full_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_wr_s | grant_rd_s) begin
          if (grant_misal_s) begin
            // Misaligned accesses never reach the core.
            state_s = grant_wr_s ? ST_BRESP : ST_RRESP;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (req_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (rsp_valid | timeout_s) begin
          state_s = cur_write_r ? ST_BRESP : ST_RRESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_BRESP: begin
        if (s_axil.s_bready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BRESP;
        end
      end
      ST_RRESP: begin
        if (s_axil.s_rready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RRESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Transaction context: payload, response code, read data, pointer, wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_write_r <= 1'b1;
      cur_write_r <= 1'b0;
      req_addr_r  <= ADDR_ZERO;
      req_wdata_r <= DATA_ZERO;
      req_wstrb_r <= STRB_ZERO;
      resp_r      <= RESP_OKAY;
      rdata_r     <= DATA_ZERO;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_wr_s | grant_rd_s) begin
            cur_write_r <= grant_wr_s;
            req_addr_r  <= grant_addr_s;
            req_wdata_r <= grant_wr_s ? w_data_r : DATA_ZERO;
            req_wstrb_r <= grant_wr_s ? w_strb_r : STRB_ZERO;
            resp_r      <= grant_misal_s ? RESP_SLVERR : RESP_OKAY;
            rdata_r     <= DATA_ZERO;
            if (wr_pend_s & rd_pend_s) begin
              ptr_write_r <= ~ptr_write_r;
            end
          end
        end
        ST_REQ: begin
          if (req_ready) begin
            cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + CNT_W'(1'b1);
          if (rsp_valid) begin
            resp_r  <= rsp_err ? RESP_SLVERR : RESP_OKAY;
            rdata_r <= cur_write_r ? DATA_ZERO : rsp_rdata;
          end else if (timeout_s) begin
            resp_r  <= RESP_SLVERR;
            rdata_r <= DATA_ZERO;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs decoded from the state and context registers
  always_comb begin
    req_valid          = (state_r == ST_REQ);
    req_write          = cur_write_r;
    req_addr           = req_addr_r;
    req_wdata          = req_wdata_r;
    req_wstrb          = req_wstrb_r;
    busy               = (state_r != ST_IDLE);
    s_axil.s_awready   = awready_r;
    s_axil.s_wready    = wready_r;
    s_axil.s_arready   = arready_r;
    s_axil.s_rdata     = rdata_r;
    if (state_r == ST_BRESP) begin
      s_axil.s_bvalid = 1'b1;
      s_axil.s_bresp  = resp_r;
    end else begin
      s_axil.s_bvalid = 1'b0;
      s_axil.s_bresp  = RESP_OKAY;
    end
    if (state_r == ST_RRESP) begin
      s_axil.s_rvalid = 1'b1;
      s_axil.s_rresp  = resp_r;
    end else begin
      s_axil.s_rvalid = 1'b0;
      s_axil.s_rresp  = RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axil_ctrl_bridge.sv
// ----------------------------------------------------------------------------
// tb_axil_ctrl_bridge
// Directed bench for axil_ctrl_bridge (ADDR 12, DATA 32, TIMEOUT 4). A small
// core model answers each request one cycle after the handshake and logs the
// request payload; the main sequence drives AXI4-Lite traffic and compares
// against hand-computed values.
// ----------------------------------------------------------------------------
module tb_axil_ctrl_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // core model controls and request log
  bit            core_en = 1'b1;
  logic [DW-1:0] core_rdata = 32'h0000_0000;
  logic          core_err = 1'b0;
  int            late_req = 0;
  int            n_req = 0;
  logic          wr_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] wdata_q[$];
  logic [SW-1:0] wstrb_q[$];

  always #5 clk = ~clk;

  axil_ctrl_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil_if ();

  axil_ctrl_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_axil   (axil_if.slave),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model: logs each accepted request, answers one cycle later when enabled.
  initial begin
    int pend;
    int late_done;
    pend = 0;
    late_done = 0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0000_0000;
    rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rsp_valid = 1'b1;
          rsp_rdata = core_rdata;
          rsp_err   = core_err;
        end
      end
      if (late_req != late_done) begin
        late_done = late_req;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hFFFF_FFFF;
        rsp_err   = 1'b0;
      end
      if (req_valid && req_ready) begin
        n_req++;
        wr_q.push_back(req_write);
        addr_q.push_back(req_addr);
        wdata_q.push_back(req_wdata);
        wstrb_q.push_back(req_wstrb);
        if (core_en) pend = 1;
      end
    end
  end

  // Present any mix of AW/W/AR together; each valid drops after its handshake.
  task automatic axi_send(input logic do_aw, input logic do_w, input logic do_ar,
                          input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] wstrb, input logic [AW-1:0] raddr);
    logic aw_hs, w_hs, ar_hs;
    int cyc;
    axil_if.s_awaddr  = waddr;
    axil_if.s_wdata   = wdata;
    axil_if.s_wstrb   = wstrb;
    axil_if.s_araddr  = raddr;
    axil_if.s_awvalid = do_aw;
    axil_if.s_wvalid  = do_w;
    axil_if.s_arvalid = do_ar;
    cyc = 0;
    while ((axil_if.s_awvalid || axil_if.s_wvalid || axil_if.s_arvalid) && cyc < 20) begin
      aw_hs = axil_if.s_awvalid & axil_if.s_awready;
      w_hs  = axil_if.s_wvalid  & axil_if.s_wready;
      ar_hs = axil_if.s_arvalid & axil_if.s_arready;
      @(negedge clk);
      cyc++;
      if (aw_hs) axil_if.s_awvalid = 1'b0;
      if (w_hs)  axil_if.s_wvalid  = 1'b0;
      if (ar_hs) axil_if.s_arvalid = 1'b0;
    end
    check_eq("send_accepted", {axil_if.s_awvalid, axil_if.s_wvalid, axil_if.s_arvalid}, 3'b000);
    axil_if.s_awvalid = 1'b0;
    axil_if.s_wvalid  = 1'b0;
    axil_if.s_arvalid = 1'b0;
  endtask

  // Wait for B, hold bready low for 'hold' cycles checking stability, then accept.
  task automatic take_b(input string tag, input logic [1:0] exp, input int hold, output int cyc);
    cyc = 0;
    while (!axil_if.s_bvalid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_bvalid"}, axil_if.s_bvalid, 1'b1);
    check_eq({tag, "_bresp"}, axil_if.s_bresp, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_bhold"}, {axil_if.s_bvalid, axil_if.s_bresp}, {1'b1, exp});
    end
    axil_if.s_bready = 1'b1;
    @(negedge clk);
    axil_if.s_bready = 1'b0;
    check_eq({tag, "_bdone"}, axil_if.s_bvalid, 1'b0);
  endtask

  // Wait for R, hold rready low for 'hold' cycles checking stability, then accept.
  task automatic take_r(input string tag, input logic [1:0] exp, input logic [DW-1:0] exp_data,
                        input int hold);
    int cyc;
    cyc = 0;
    while (!axil_if.s_rvalid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_rvalid"}, axil_if.s_rvalid, 1'b1);
    check_eq({tag, "_rresp"}, axil_if.s_rresp, exp);
    check_eq({tag, "_rdata"}, axil_if.s_rdata, exp_data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "_rhold"}, {axil_if.s_rvalid, axil_if.s_rresp, axil_if.s_rdata},
               {1'b1, exp, exp_data});
    end
    axil_if.s_rready = 1'b1;
    @(negedge clk);
    axil_if.s_rready = 1'b0;
    check_eq({tag, "_rdone"}, axil_if.s_rvalid, 1'b0);
  endtask

  task automatic wait_req_valid();
    int cyc;
    cyc = 0;
    while (!req_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("req_seen", req_valid, 1'b1);
  endtask

  initial begin
    int base;
    int cyc;
    bit saw_b;
    bit saw_r;
    req_ready         = 1'b1;
    axil_if.s_awaddr  = 12'h000;
    axil_if.s_awvalid = 1'b0;
    axil_if.s_wdata   = 32'h0000_0000;
    axil_if.s_wstrb   = 4'h0;
    axil_if.s_wvalid  = 1'b0;
    axil_if.s_bready  = 1'b0;
    axil_if.s_araddr  = 12'h000;
    axil_if.s_arvalid = 1'b0;
    axil_if.s_rready  = 1'b0;

    // reset state
    #12;
    check_eq("rst_awready", axil_if.s_awready, 1'b0);
    check_eq("rst_wready", axil_if.s_wready, 1'b0);
    check_eq("rst_arready", axil_if.s_arready, 1'b0);
    check_eq("rst_valids", {axil_if.s_bvalid, axil_if.s_rvalid, req_valid, busy}, 4'b0000);
    check_eq("rst_resp_data", {axil_if.s_bresp, axil_if.s_rresp, axil_if.s_rdata}, 36'h0);
    check_eq("rst_req", {req_write, req_addr, req_wdata, req_wstrb}, 49'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_ready", {axil_if.s_awready, axil_if.s_wready, axil_if.s_arready}, 3'b111);

    // W three cycles ahead of AW, then OK write with latency check
    base = n_req;
    core_err = 1'b0;
    axi_send(1'b0, 1'b1, 1'b0, 12'h000, 32'hDEAD_BEEF, 4'hF, 12'h000);
    repeat (2) @(negedge clk);
    check_eq("w_only_no_req", n_req - base, 0);
    check_eq("w_only_idle", busy, 1'b0);
    axi_send(1'b1, 1'b0, 1'b0, 12'h010, 32'h0000_0000, 4'h0, 12'h000);
    take_b("wr1", 2'b00, 3, cyc);
    check_eq("wr1_latency", cyc, 3);
    check_eq("wr1_nreq", n_req - base, 1);
    check_eq("wr1_payload", {wr_q[base], addr_q[base], wdata_q[base], wstrb_q[base]},
             {1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF});

    // read with rready held low for 5 cycles
    base = n_req;
    core_rdata = 32'h1234_5678;
    axi_send(1'b0, 1'b0, 1'b1, 12'h000, 32'h0000_0000, 4'h0, 12'h020);
    take_r("rd1", 2'b00, 32'h1234_5678, 5);
    check_eq("rd1_req", {n_req - base, wr_q[base], addr_q[base]}, {32'd1, 1'b0, 12'h020});

    // wstrb=0 still reaches the core; core error maps to SLVERR
    base = n_req;
    core_err = 1'b1;
    axi_send(1'b1, 1'b1, 1'b0, 12'h018, 32'h0000_1111, 4'h0, 12'h000);
    take_b("wr_err", 2'b10, 0, cyc);
    check_eq("wr_err_req", {n_req - base, wstrb_q[base]}, {32'd1, 4'h0});
    core_err = 1'b0;

    // round-robin: fresh reset, write wins first, read wins the second pair
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    base = n_req;
    core_rdata = 32'h0BAD_F00D;
    axi_send(1'b1, 1'b1, 1'b1, 12'h030, 32'hA5A5_0001, 4'h3, 12'h034);
    take_b("rr1", 2'b00, 0, cyc);
    take_r("rr1", 2'b00, 32'h0BAD_F00D, 0);
    check_eq("rr1_order", {n_req - base, wr_q[base], wr_q[base+1]}, {32'd2, 1'b1, 1'b0});
    check_eq("rr1_partial_strb", {wdata_q[base], wstrb_q[base]}, {32'hA5A5_0001, 4'h3});
    base = n_req;
    core_rdata = 32'h7777_0002;
    axi_send(1'b1, 1'b1, 1'b1, 12'h038, 32'h0000_0055, 4'hF, 12'h03C);
    take_r("rr2", 2'b00, 32'h7777_0002, 0);
    take_b("rr2", 2'b00, 0, cyc);
    check_eq("rr2_order", {n_req - base, wr_q[base], wr_q[base+1]}, {32'd2, 1'b0, 1'b1});

    // misaligned read and write bypass the core
    base = n_req;
    axi_send(1'b0, 1'b0, 1'b1, 12'h000, 32'h0000_0000, 4'h0, 12'h006);
    take_r("misal_rd", 2'b10, 32'h0000_0000, 0);
    axi_send(1'b1, 1'b1, 1'b0, 12'h00A, 32'h1111_2222, 4'hF, 12'h000);
    take_b("misal_wr", 2'b10, 0, cyc);
    check_eq("misal_no_req", n_req - base, 0);

    // timeout: core never answers
    core_en = 1'b0;
    axi_send(1'b1, 1'b1, 1'b0, 12'h040, 32'h0000_0040, 4'hF, 12'h000);
    wait_req_valid();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!axil_if.s_bvalid && cyc < 30);
    check_eq("to_edges_after_hs", cyc - 1, 4);
    take_b("to", 2'b10, 0, cyc);
    late_req++;
    saw_b = 1'b0;
    saw_r = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_b |= axil_if.s_bvalid;
      saw_r |= axil_if.s_rvalid;
    end
    check_eq("late_rsp_dropped", {saw_b, saw_r, busy}, 3'b000);

    // reset while waiting on the core
    axi_send(1'b0, 1'b0, 1'b1, 12'h000, 32'h0000_0000, 4'h0, 12'h050);
    wait_req_valid();
    @(negedge clk);
    check_eq("wait_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_valids",
             {busy, req_valid, axil_if.s_bvalid, axil_if.s_rvalid, axil_if.s_arready}, 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;
    core_en = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_quiet", {axil_if.s_bvalid, axil_if.s_rvalid, busy}, 3'b000);
    base = n_req;
    core_rdata = 32'hCAFE_0123;
    axi_send(1'b0, 1'b0, 1'b1, 12'h000, 32'h0000_0000, 4'h0, 12'h060);
    take_r("post_rst_rd", 2'b00, 32'hCAFE_0123, 0);
    check_eq("post_rst_req", {n_req - base, addr_q[base]}, {32'd1, 12'h060});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
